// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding
// {main_valid, skid_valid} and the default payload width.
package pipe_pkg;

  localparam int PIPE_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear (clear wins).
// Holds its value when neither clear nor load is asserted.
module pipe_data_reg #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clk,
  input  logic             i_Clear,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_Clk) begin
    if (i_Clear) begin
      r_data <= '0;
    end else if (i_Load) begin
      r_data <= i_Data;
    end
  end

  assign o_Data = r_data;

endmodule : pipe_data_reg

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered valid/ready pipeline stage with synchronous flush.
// Define PIPE_SKID_PERF_EN to add saturating stall / full-occupancy counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = PIPE_DATA_WIDTH,
  parameter int FLUSH_ZERO  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Flush,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [DATA_WIDTH-1:0] o_Data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [COUNT_WIDTH-1:0] o_Stall_Count,
  output logic [COUNT_WIDTH-1:0] o_Full_Count
`endif
);

  pipe_state_e           r_state;
  pipe_state_e           w_state_next;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_main_load;
  logic                  w_skid_load;
  logic                  w_main_from_skid;
  logic                  w_clear;
  logic [DATA_WIDTH-1:0] w_main_d;
  logic [DATA_WIDTH-1:0] w_skid_q;

  // Both handshake outputs are plain flop bits of the occupancy state.
  assign o_Valid    = r_state[1];
  assign o_Ready    = ~r_state[0];
  assign w_in_fire  = i_Valid & o_Ready;
  assign w_out_fire = o_Valid & i_Ready;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = ST_ONE;
          w_main_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load  = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = ST_TWO;
          w_skid_load  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_state_next     = ST_ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    // Flush drops any accepted beat; an outgoing beat has already been taken.
    if (i_Flush) begin
      w_state_next = ST_EMPTY;
      w_main_load  = 1'b0;
      w_skid_load  = 1'b0;
    end
  end

  assign w_clear  = i_Reset | (i_Flush & (FLUSH_ZERO != 0));
  assign w_main_d = w_main_from_skid ? w_skid_q : i_Data;

  pipe_data_reg #(.WIDTH(DATA_WIDTH)) u_main_reg (
    .i_Clk   (i_Clk),
    .i_Clear (w_clear),
    .i_Load  (w_main_load),
    .i_Data  (w_main_d),
    .o_Data  (o_Data)
  );

  pipe_data_reg #(.WIDTH(DATA_WIDTH)) u_skid_reg (
    .i_Clk   (i_Clk),
    .i_Clear (w_clear),
    .i_Load  (w_skid_load),
    .i_Data  (i_Data),
    .o_Data  (w_skid_q)
  );

`ifdef PIPE_SKID_PERF_EN
  logic [COUNT_WIDTH-1:0] r_stall_count;
  logic [COUNT_WIDTH-1:0] r_full_count;

  // Saturating counters; flush leaves them untouched.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_stall_count <= '0;
      r_full_count  <= '0;
    end else begin
      if (o_Valid && !i_Ready && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if ((r_state == ST_TWO) && (r_full_count != '1)) begin
        r_full_count <= r_full_count + 1'b1;
      end
    end
  end

  assign o_Stall_Count = r_stall_count;
  assign o_Full_Count  = r_full_count;
`endif

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random traffic against a
// two-deep FIFO reference model; optional counter checks with PIPE_SKID_PERF_EN.
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int FZ = 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready_dut;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          ds_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] full_cnt;
`endif

  pipe_skid_stage #(
    .DATA_WIDTH  (DW),
    .FLUSH_ZERO  (FZ),
    .COUNT_WIDTH (CW)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Flush       (flush),
    .i_Valid       (in_valid),
    .o_Ready       (out_ready_dut),
    .i_Data        (in_data),
    .o_Valid       (out_valid),
    .i_Ready       (ds_ready),
    .o_Data        (out_data)
`ifdef PIPE_SKID_PERF_EN
    ,
    .o_Stall_Count (stall_cnt),
    .o_Full_Count  (full_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a FIFO of at most two entries plus the last shown word.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last = '0;
  int            m_stall = 0;
  int            m_full  = 0;
  int            m_emits = 0;
  int            dut_emits = 0;
  int            max_cnt = (1 << CW) - 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic fl, input logic rs);
    logic ready_a, ready_b, exp_ready, in_fire, out_fire;
    int   line;
    in_valid = v; in_data = d; ds_ready = r; flush = fl; rst = rs;
    exp_ready = (m_q.size() < 2);
    // Ready must not follow i_Ready within the cycle.
    #1 ready_a = out_ready_dut;
    ds_ready = ~r;
    #1 ready_b = out_ready_dut;
    ds_ready = r;
    #1;
    chk("ready_pre_a", {31'b0, ready_a}, {31'b0, exp_ready});
    chk("ready_pre_b", {31'b0, ready_b}, {31'b0, exp_ready});
    if (out_valid && r) dut_emits++;
    in_fire  = v && exp_ready;
    out_fire = (m_q.size() > 0) && r;
    @(posedge clk);
    if (rs) begin
      m_q.delete(); m_last = '0; m_stall = 0; m_full = 0;
    end else begin
      if (m_q.size() > 0 && !r && m_stall < max_cnt) m_stall++;
      if (m_q.size() == 2 && m_full < max_cnt) m_full++;
      if (out_fire) m_emits++;
      if (fl) begin
        m_last = (FZ != 0) ? '0 : ((m_q.size() > 0) ? m_q[0] : m_last);
        m_q.delete();
      end else begin
        if (out_fire) m_last = m_q.pop_front();
        if (in_fire) m_q.push_back(d);
      end
    end
    #1;
    chk("o_Valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
    chk("o_Ready", {31'b0, out_ready_dut}, {31'b0, (m_q.size() < 2)});
    chk("o_Data", out_data, (m_q.size() > 0) ? m_q[0] : m_last);
`ifdef PIPE_SKID_PERF_EN
    chk("stall_count", {28'b0, stall_cnt}, DW'(m_stall));
    chk("full_count", {28'b0, full_cnt}, DW'(m_full));
`endif
    line = 0;
  endtask

  initial begin
    in_valid = 0; in_data = '0; ds_ready = 0; flush = 0; rst = 1;
    @(posedge clk);
    #1;
    // Reset for two cycles, then a back-to-back stream.
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    chk("reset_data", out_data, '0);
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("stream_last", out_data, 32'h8);

    // Backpressure: A, B accepted, C held off until space frees.
    step(1, 32'hA, 1, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0);
    chk("bp_hold_a", out_data, 32'hA);
    step(1, 32'hC, 0, 0, 0);
    step(1, 32'hC, 1, 0, 0);
    step(1, 32'hC, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);

    // Flush while full, with a beat offered in the same cycle.
    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0);
    step(1, 32'h33, 0, 1, 0);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_data", out_data, '0);
    for (int i = 0; i < 2; i++) step(0, '0, 1, 0, 0);

    // Reset beats flush while one entry is held.
    step(1, 32'h55, 0, 0, 0);
    step(1, 32'h66, 0, 1, 1);
    chk("rst_prio_ready", {31'b0, out_ready_dut}, 32'h1);

`ifdef PIPE_SKID_PERF_EN
    // Counter saturation: one entry, then two, stalled for 20 cycles.
    step(1, 32'h77, 0, 0, 0);
    step(1, 32'h88, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0);
    chk("stall_sat", {28'b0, stall_cnt}, 32'hF);
    step(0, '0, 1, 1, 0);
    step(0, '0, 0, 0, 1);
`endif

    // Random traffic with rare flushes.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
    chk("emit_count", DW'(dut_emits), DW'(m_emits));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pipe_skid_stage
